uart_transceiver_cfg: RTL

Parametrised, runtime-configurable UART transceiver, the successor to the fixed 8N1 transceiver. It adds a built-in baud divider, configurable data width, an oversampling ratio, a parity mode and 1 or 2 stop bits. It also reports receive errors (framing, parity, break). It sits between the register/bus front-end and the board UART pins, with one instance per serial channel.

---
 rtl/uart_transceiver_cfg.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_transceiver_cfg.sv
// Runtime-configurable UART transceiver: shared baud divider, 2^OS_LOG2 oversampling, DATA_BITS data,
//   parity none/even/odd, 1 or 2 TX stop bits, RX framing/parity/break reporting.
// Latency: uart_tx drops one cycle after an accepted tx_wr; rx_done is raised at the middle of the first stop bit.
// Backpressure: tx_wr is honoured only while tx_busy=0 (otherwise dropped); RX has no backpressure, so rx_data is overwritten on each rx_done.
// Ports: sys_clk/sys_rst (sync, active-high); divisor, parity_mode, two_stop = configuration;
//   uart_rx/uart_tx = pins; rx_* = receive word, strobe and error flags;
//   tx_data/tx_wr/tx_busy/tx_done = transmit interface.
module uart_transceiver_cfg #(
  parameter int DATA_BITS = 8,
  parameter int OS_LOG2   = 4,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_break,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DATA_BITS - 1);
  localparam logic [OS_LOG2-1:0] OS_MAX     = '1;
  localparam logic [OS_LOG2-1:0] OS_HALF_M1 = OS_LOG2'((1 << (OS_LOG2 - 1)) - 1);

  // ---------------------------------------------------------------- divider
  // The active divisor is only reloaded on a wrap, so a mid-period change
  // never produces a short or runaway tick period.
  logic [DIV_WIDTH-1:0] div_cnt, div_lat, div_eff;
  logic                 tick;

  assign div_eff = (divisor == '0) ? DIV_WIDTH'(1) : divisor;
  assign tick    = (div_cnt == div_lat - DIV_WIDTH'(1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      div_cnt <= '0;
      div_lat <= div_eff;
    end else if (tick) begin
      div_cnt <= '0;
      div_lat <= div_eff;
    end else begin
      div_cnt <= div_cnt + DIV_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------- transmitter
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  tx_state_t            tx_state, tx_state_n;
  logic [OS_LOG2-1:0]   tx_cnt, tx_cnt_n;
  logic [IDX_W-1:0]     tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic                 tx_pen, tx_pen_n, tx_pbit, tx_pbit_n, tx_two, tx_two_n;
  logic                 tx_line_n, tx_done_n;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx_pen   <= 1'b0;
      tx_pbit  <= 1'b0;
      tx_two   <= 1'b0;
      uart_tx  <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_sh    <= tx_sh_n;
      tx_pen   <= tx_pen_n;
      tx_pbit  <= tx_pbit_n;
      tx_two   <= tx_two_n;
      uart_tx  <= tx_line_n;
      tx_done  <= tx_done_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_sh_n    = tx_sh;
    tx_pen_n   = tx_pen;
    tx_pbit_n  = tx_pbit;
    tx_two_n   = tx_two;
    case (tx_state)
      TX_IDLE: begin
        if (tx_wr) begin
          // Word, parity bit and stop count are frozen for the whole frame.
          tx_state_n = TX_START;
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          tx_sh_n    = tx_data;
          tx_pen_n   = ^parity_mode;
          tx_pbit_n  = parity_mode[1] ? ~^tx_data : ^tx_data;
          tx_two_n   = two_stop;
        end
      end
      default: begin
        if (tick) begin
          if (tx_cnt != OS_MAX) begin
            tx_cnt_n = tx_cnt + 1'b1;
          end else begin
            tx_cnt_n = '0;
            case (tx_state)
              TX_START: begin
                tx_state_n = TX_DATA;
                tx_idx_n   = '0;
              end
              TX_DATA: begin
                tx_sh_n = tx_sh >> 1;
                if (tx_idx == LAST_IDX) begin
                  tx_idx_n   = '0;
                  tx_state_n = tx_pen ? TX_PARITY : TX_STOP;
                end else begin
                  tx_idx_n = tx_idx + 1'b1;
                end
              end
              TX_PARITY: begin
                tx_state_n = TX_STOP;
                tx_idx_n   = '0;
              end
              TX_STOP: begin
                // idx 0 is the first stop bit, idx 1 the optional second one.
                if (tx_idx[0] == tx_two) tx_state_n = TX_IDLE;
                else                     tx_idx_n   = tx_idx + 1'b1;
              end
              default: tx_state_n = TX_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // The pin is registered, so its next value is derived from the next state.
  always_comb begin
    tx_line_n = 1'b1;
    case (tx_state_n)
      TX_START:  tx_line_n = 1'b0;
      TX_DATA:   tx_line_n = tx_sh_n[0];
      TX_PARITY: tx_line_n = tx_pbit_n;
      default:   tx_line_n = 1'b1;
    endcase
    tx_done_n = (tx_state == TX_STOP) && (tx_state_n == TX_IDLE);
  end

  assign tx_busy = (tx_state != TX_IDLE);

  // ---------------------------------------------------------------- receiver
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  rx_state_t            rx_state, rx_state_n;
  logic                 rx_s1, rx_s2;
  logic [OS_LOG2-1:0]   rx_cnt, rx_cnt_n;
  logic [IDX_W-1:0]     rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic                 rx_pen, rx_pen_n, rx_podd, rx_podd_n, rx_pbit, rx_pbit_n;
  logic                 rx_sample;
  logic [DATA_BITS-1:0] rx_data_n;
  logic                 rx_done_n, rx_fe_n, rx_pe_n, rx_brk_n;

  // rx_cnt counts down to the next mid-bit sample point.
  assign rx_sample = tick && (rx_cnt == '0);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_sh         <= '0;
      rx_pen        <= 1'b0;
      rx_podd       <= 1'b0;
      rx_pbit       <= 1'b0;
      rx_data       <= '0;
      rx_done       <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_break      <= 1'b0;
    end else begin
      rx_s1         <= uart_rx;
      rx_s2         <= rx_s1;
      rx_state      <= rx_state_n;
      rx_cnt        <= rx_cnt_n;
      rx_idx        <= rx_idx_n;
      rx_sh         <= rx_sh_n;
      rx_pen        <= rx_pen_n;
      rx_podd       <= rx_podd_n;
      rx_pbit       <= rx_pbit_n;
      rx_data       <= rx_data_n;
      rx_done       <= rx_done_n;
      rx_frame_err  <= rx_fe_n;
      rx_parity_err <= rx_pe_n;
      rx_break      <= rx_brk_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_sh_n    = rx_sh;
    rx_pen_n   = rx_pen;
    rx_podd_n  = rx_podd;
    rx_pbit_n  = rx_pbit;
    case (rx_state)
      RX_IDLE: begin
        if (tick && !rx_s2) begin
          rx_state_n = RX_START;
          rx_cnt_n   = OS_HALF_M1;
          rx_pen_n   = ^parity_mode;
          rx_podd_n  = parity_mode[1];
        end
      end
      RX_WAIT_HIGH: begin
        if (tick && rx_s2) rx_state_n = RX_IDLE;
      end
      default: begin
        if (tick) begin
          if (rx_cnt != '0) begin
            rx_cnt_n = rx_cnt - 1'b1;
          end else begin
            rx_cnt_n = OS_MAX;
            case (rx_state)
              RX_START: begin
                // A start bit that is high again by mid-bit was a glitch.
                rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                rx_idx_n   = '0;
              end
              RX_DATA: begin
                rx_sh_n = {rx_s2, rx_sh[DATA_BITS-1:1]};
                if (rx_idx == LAST_IDX) rx_state_n = rx_pen ? RX_PARITY : RX_STOP;
                else                    rx_idx_n   = rx_idx + 1'b1;
              end
              RX_PARITY: begin
                rx_pbit_n  = rx_s2;
                rx_state_n = RX_STOP;
              end
              RX_STOP:  rx_state_n = rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
              default:  rx_state_n = RX_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // Flags are held between frames and only refreshed together with rx_done.
  always_comb begin
    rx_done_n = (rx_state == RX_STOP) && rx_sample;
    rx_data_n = rx_data;
    rx_fe_n   = rx_frame_err;
    rx_pe_n   = rx_parity_err;
    rx_brk_n  = rx_break;
    if (rx_done_n) begin
      rx_data_n = rx_sh;
      rx_fe_n   = ~rx_s2;
      rx_pe_n   = rx_pen && ((^rx_sh ^ rx_pbit) != rx_podd);
      rx_brk_n  = ~rx_s2 && (rx_sh == '0) && !(rx_pen && rx_pbit);
    end
  end

endmodule
